// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its IF/ID register: FSM encoding,
// default NOP encoding and the IF/ID bundle that decode also consumes.
package instr_fetch_stage_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               valid;
  } if_id_t;

  // A fetch address is usable only if word aligned and inside the memory.
  function automatic logic fetch_addr_ok(input logic [PC_W-1:0] addr,
                                         input logic [PC_W-1:0] mem_bytes);
    return (addr[1:0] == 2'b00) && (addr < mem_bytes);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
// A flush replaces the instruction with NOP and clears valid; PC fields keep their value.
module if_id_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t load_data,
  output if_id_t if_id
);

  if_id_t if_id_d;
  if_id_t if_id_q;

  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (load) begin
      if_id_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id = if_id_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Pipeline front end: owns the PC, drives instruction memory and fills IF/ID.
// Bad fetch addresses park the stage in HALT until reset.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int               IMEM_DEPTH = 64,
  parameter logic [PC_W-1:0]  RESET_PC   = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  localparam int              AW         = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               fetch_fault
);

  localparam logic [PC_W-1:0] MEM_BYTES = PC_W'(4 * IMEM_DEPTH);

  fetch_state_e    state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic            fault_d, fault_q;
  logic [PC_W-1:0] pc_plus4;
  logic            if_load;
  logic            if_flush;
  if_id_t          if_id_load_data;
  if_id_t          if_id;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q[AW+1:2];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    if_load  = 1'b0;
    if_flush = 1'b0;
    case (state_q)
      WARMUP: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          if_flush = 1'b1;
          if (fetch_addr_ok(redirect_pc, MEM_BYTES)) begin
            pc_d = redirect_pc;
          end else begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        end else if (!stall) begin
          if_load = 1'b1;
          // The last word is still delivered; the PC never wraps back to 0.
          if (pc_plus4 == MEM_BYTES) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALT: begin
        if_flush = 1'b1;
        fault_d  = 1'b1;
      end
      default: begin
        state_d  = HALT;
        fault_d  = 1'b1;
        if_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WARMUP;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign if_id_load_data = '{instr: imem_rdata, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (if_load),
    .flush     (if_flush),
    .load_data (if_id_load_data),
    .if_id     (if_id)
  );

  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_valid    = if_id.valid;
  assign fetch_fault    = fault_q;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Pipeline front end that drives the 64-word instruction memory and produces the IF/ID pipeline register consumed by the decode stage.
Holds the PC and sequences it: increment, hold on hazard stall, or jump on branch/jump redirect with flush.
Detects misaligned or out-of-range fetch addresses and halts fetch cleanly so simulation runs end deterministically.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of two)
RESET_PC, 32'h0000_0000, PC value loaded by reset
NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID on flush or bubble

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_addr  out  $clog2(IMEM_DEPTH)  word index into instruction memory (pc[AW+1:2])
imem_rdata  in  32  instruction word; combinational read of imem_addr in the same cycle
stall  in  1  hazard unit hold request: freeze PC and IF/ID
redirect_valid  in  1  branch/jump taken, from EX
redirect_pc  in  32  target byte address
if_id_instr  out  32  registered instruction
if_id_pc  out  32  registered byte PC of if_id_instr
if_id_pc_plus4  out  32  registered if_id_pc + 4
if_id_valid  out  1  registered: IF/ID holds a real instruction
fetch_fault  out  1  registered, sticky: fetch halted on bad address

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_PC, state=WARMUP, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, fetch_fault=0.
- imem_addr is combinational from pc: pc[AW+1:2], where AW=$clog2(IMEM_DEPTH).
- FSM states:
  WARMUP: exactly one cycle after reset release; no fetch, IF/ID keeps its reset values; next state RUN. This gives memory initialisation time to settle.
  RUN: normal fetch.
  HALT: entered on a fault; pc frozen; IF/ID holds NOP_INSTR with if_id_valid=0; fetch_fault=1. HALT is left only by reset.
- RUN, per rising edge, in priority order:
  1. redirect_valid=1:
     - if redirect_pc[1:0]!=0 or redirect_pc >= 4*IMEM_DEPTH -> HALT, fetch_fault<=1.
     - else pc<=redirect_pc.
     - Either way, IF/ID <= {NOP_INSTR, valid=0} (flush). Redirect wins over a simultaneous stall.
  2. stall=1: pc and all IF/ID outputs hold their values.
  3. Otherwise:
     - IF/ID <= {imem_rdata, pc, pc+4, valid=1}.
     - if pc+4 == 4*IMEM_DEPTH, the fetch of the last word still completes, then -> HALT, fetch_fault<=1, with no wrap to 0.
     - else pc<=pc+4.
- Latency: instruction at PC p appears on if_id_* one cycle after pc==p in RUN with no stall.
- Throughput: one instruction per cycle.
- Arithmetic: pc+4 is computed in 32 bits; the range check prevents 32-bit wrap from ever being used.
- Redirect or stall during WARMUP: ignored (EX holds no valid instruction then).
- Reset asserted mid-operation: all state returns to reset values immediately; the fault is cleared.

Decomposition:
- Shared package holds:
  - FSM state encoding: WARMUP=2'd0, RUN=2'd1, HALT=2'd2.
  - NOP_INSTR default.
  - IF/ID bundle field widths, so decode uses the same definitions.
- One sub-module: if_id_reg, the IF/ID pipeline register with load/hold/flush controls and asynchronous active-low reset.
- PC logic and FSM stay in instr_fetch_stage.

Test Plan:
- Reset then free run: memory word k = 32'hA000_0000+k, no stall/redirect.
  -> if_id_valid=0 for the first 2 edges.
  -> then if_id_instr=A0000000, A0000001, ... on consecutive cycles, with if_id_pc=0,4,8,...
- Stall held 3 cycles while if_id_pc=8.
  -> if_id_pc=8, instr=A0000002 and pc are held for 3 cycles.
  -> after release, if_id_pc=12 appears on the next edge.
- redirect_valid with redirect_pc=32'h40 asserted together with stall.
  -> next edge: if_id_valid=0, instr=NOP.
  -> following edge: if_id_pc=0x40, instr=A0000010.
- Misaligned redirect_pc=32'h42.
  -> fetch_fault=1 and if_id_valid=0 from the next edge on; the state persists through 10 further cycles and any further redirect.
- Run to end of memory.
  -> if_id_pc=0xFC with A000003F is delivered.
  -> next edge fetch_fault=1 and if_id_valid=0; imem_addr never returns to 0.
- Assert reset mid-run at if_id_pc=0x20.
  -> all outputs go to reset values asynchronously, before the next clock edge.
  -> after release: one WARMUP cycle, then fetch restarts at PC 0.
